// File: rtl/fetch_decode_queue_if.sv
// Fetch/decode handshake bundle for the fetch-to-decode elastic queue.
// The master side is the fetch/decode environment; the slave side is the queue.
interface fetch_decode_queue_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 3
);
  logic               flush;
  logic               wr_valid;
  logic               wr_ready;
  logic [PC_W-1:0]    wr_pc;
  logic [INSTR_W-1:0] wr_instr;
  logic               rd_valid;
  logic               rd_ready;
  logic [PC_W-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic [CNT_W-1:0]   count;

  modport master (
    output flush, wr_valid, wr_pc, wr_instr, rd_ready,
    input  wr_ready, rd_valid, rd_pc, rd_instr, count
  );

  modport slave (
    input  flush, wr_valid, wr_pc, wr_instr, rd_ready,
    output wr_ready, rd_valid, rd_pc, rd_instr, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// In-order {PC, instruction} queue between fetch and decode with branch flush.
// Flags and head data are registered, so no input reaches an output combinationally.
module fetch_decode_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fetch_decode_queue_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PC_W-1:0]    r_mem_pc    [DEPTH];
  logic [INSTR_W-1:0] r_mem_instr [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_rd_valid;
  logic               r_wr_ready;
  logic [PC_W-1:0]    r_rd_pc;
  logic [INSTR_W-1:0] r_rd_instr;

  logic               w_wr;
  logic               w_rd;
  logic [AW-1:0]      w_wr_ptr_nxt;
  logic [AW-1:0]      w_rd_ptr_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [PC_W-1:0]    w_rd_pc_nxt;
  logic [INSTR_W-1:0] w_rd_instr_nxt;

  assign w_wr = bus.wr_valid & r_wr_ready;
  assign w_rd = r_rd_valid & bus.rd_ready;

  // Next pointers and occupancy; flush overrides any same-cycle transfer.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (bus.flush) begin
      w_wr_ptr_nxt = {AW{1'b0}};
      w_rd_ptr_nxt = {AW{1'b0}};
      w_count_nxt  = {CNT_W{1'b0}};
    end else begin
      if (w_wr) begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_rd) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_wr, w_rd})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Next head: an entry written this cycle becomes the head when it lands on the next read slot.
  always_comb begin
    w_rd_pc_nxt    = {PC_W{1'b0}};
    w_rd_instr_nxt = {INSTR_W{1'b0}};
    if (w_count_nxt == {CNT_W{1'b0}}) begin
      w_rd_pc_nxt    = {PC_W{1'b0}};
      w_rd_instr_nxt = {INSTR_W{1'b0}};
    end else if (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_rd_pc_nxt    = bus.wr_pc;
      w_rd_instr_nxt = bus.wr_instr;
    end else begin
      w_rd_pc_nxt    = r_mem_pc[w_rd_ptr_nxt];
      w_rd_instr_nxt = r_mem_instr[w_rd_ptr_nxt];
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr && !bus.flush) begin
      r_mem_pc[r_wr_ptr]    <= bus.wr_pc;
      r_mem_instr[r_wr_ptr] <= bus.wr_instr;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= {AW{1'b0}};
      r_rd_ptr   <= {AW{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b1;
      r_rd_pc    <= {PC_W{1'b0}};
      r_rd_instr <= {INSTR_W{1'b0}};
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_count_nxt;
      r_rd_valid <= (w_count_nxt != {CNT_W{1'b0}});
      r_wr_ready <= (w_count_nxt != FULL);
      r_rd_pc    <= w_rd_pc_nxt;
      r_rd_instr <= w_rd_instr_nxt;
    end
  end

  assign bus.wr_ready = r_wr_ready;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_pc    = r_rd_pc;
  assign bus.rd_instr = r_rd_instr;
  assign bus.count    = r_count;
endmodule
